// File: rtl/clz_share_arbiter.sv
// Round-robin arbiter sharing one count-leading-zeros unit between NUM_REQ clients,
// with a single registered result stage. Define CLZ_NORM_EN to add the normalised-operand output.
module clz_share_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int IDW     = $clog2(NUM_REQ),
    localparam int CW      = $clog2(WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [CW-1:0]            rsp_count,
    output logic                     rsp_zero
`ifdef CLZ_NORM_EN
    ,
    output logic [WIDTH-1:0]         rsp_norm
`endif
);

    // Handshake: a request moves on req_valid[i] && req_ready[i]; a result is
    // consumed on rsp_valid && rsp_ready. Valid holders keep data stable until then.

    logic [IDW-1:0]   rr_ptr;
    logic             can_load;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [CW-1:0]    grant_count;
    logic             transfer;
    int               scan_idx;

    assign can_load = !rsp_valid || rsp_ready;
    assign transfer = grant_any && can_load;

    // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && transfer) req_ready[grant_idx] = 1'b1;
    end

    assign grant_data = req_data[grant_idx*WIDTH +: WIDTH];

    // Highest set bit is visited last, so it determines the count.
    always_comb begin
        grant_count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (grant_data[i]) grant_count = CW'(WIDTH - 1 - i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
            rsp_zero  <= 1'b0;
            rr_ptr    <= '0;
`ifdef CLZ_NORM_EN
            rsp_norm  <= '0;
`endif
        end else if (transfer) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant_idx;
            rsp_count <= grant_count;
            rsp_zero  <= (grant_data == '0);
            rr_ptr    <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
`ifdef CLZ_NORM_EN
            rsp_norm  <= grant_data << grant_count;
`endif
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clz_share_arbiter.sv
// Bench for clz_share_arbiter: directed scenarios plus randomized traffic checked
// against an arithmetic reference model; a second 3x5 instance covers the odd-size case.
module tb_clz_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*W-1:0] req_data  = '0;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [5:0]      rsp_count;
    logic            rsp_zero;
`ifdef CLZ_NORM_EN
    logic [W-1:0]    rsp_norm;
`endif

    logic [2:0]      rv3 = '0;
    logic [14:0]     rd3 = '0;
    logic [2:0]      rr3;
    logic            vld3;
    logic            rdy3 = 1'b0;
    logic [1:0]      id3;
    logic [2:0]      cnt3;
    logic            zero3;
`ifdef CLZ_NORM_EN
    logic [4:0]      norm3;
`endif

    always #5 clk = ~clk;

    clz_share_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_count(rsp_count), .rsp_zero(rsp_zero)
`ifdef CLZ_NORM_EN
        , .rsp_norm(rsp_norm)
`endif
    );

    clz_share_arbiter #(.NUM_REQ(3), .WIDTH(5)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_data(rd3),
        .req_ready(rr3), .rsp_valid(vld3), .rsp_ready(rdy3),
        .rsp_id(id3), .rsp_count(cnt3), .rsp_zero(zero3)
`ifdef CLZ_NORM_EN
        , .rsp_norm(norm3)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int last_grant;

    // Reference model state
    logic         m_valid;
    int           m_id, m_count, m_rr;
    logic         m_zero;
    logic [W-1:0] m_norm;
    logic [7:0]   exp_q[$];

    logic         pend[NR];
    logic [W-1:0] pdata[NR];

    function automatic int ref_clz(input logic [W-1:0] d);
        longint v;
        v = longint'({32'b0, d});
        return W - $clog2(v + 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_id = 0; m_count = 0; m_zero = 1'b0; m_norm = '0; m_rr = 0;
    endtask

    // Assumes entry at posedge+1; returns at the following posedge+1.
    task automatic step();
        int g, idx;
        logic can;
        logic [NR-1:0] er;
        logic [W-1:0] d;
        #1;
        can = !m_valid || rsp_ready;
        g = -1;
        if (can) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_rr + k) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        er = '0;
        d = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            d = req_data[g*W +: W];
        end
        check("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_valid = 1'b1; m_id = g; m_count = ref_clz(d); m_zero = (d == 0);
            m_norm = d << m_count;
            m_rr = (g + 1) % NR;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        last_grant = g;
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        if (m_valid) begin
            check("rsp_id", 64'(rsp_id), 64'(m_id));
            check("rsp_count", 64'(rsp_count), 64'(m_count));
            check("rsp_zero", 64'(rsp_zero), 64'(m_zero));
`ifdef CLZ_NORM_EN
            check("rsp_norm", 64'(rsp_norm), 64'(m_norm));
`endif
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rv3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset rsp_id", 64'(rsp_id), 64'(0));
        check("reset rsp_count", 64'(rsp_count), 64'(0));
        check("reset rsp_zero", 64'(rsp_zero), 64'(0));
        check("reset vld3", 64'(vld3), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #3;
        check("req_ready in reset", 64'(req_ready), 64'(0));
        do_reset();

        // Single request from requester 2
        req_valid = 4'b0100;
        req_data[2*W +: W] = 32'h0001_0000;
        rsp_ready = 1'b1;
        step();
        check("single id", 64'(rsp_id), 64'(2));
        check("single count", 64'(rsp_count), 64'(15));
        req_valid = '0;

        // Zero and full-scale operands
        req_valid = 4'b0001;
        req_data[0 +: W] = 32'h0;
        step();
        check("zero count", 64'(rsp_count), 64'(32));
        check("zero flag", 64'(rsp_zero), 64'(1));
        req_data[0 +: W] = 32'h8000_0000;
        step();
        check("msb count", 64'(rsp_count), 64'(0));
        req_data[0 +: W] = 32'h0000_00F0;
        step();
`ifdef CLZ_NORM_EN
        check("norm F0", 64'(rsp_norm), 64'(32'hF000_0000));
`endif
        req_valid = '0;

        // Round robin, all four requesters held valid
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i % NR));
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = $urandom;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr sequence", 64'(rsp_id), 64'(exp_q.pop_front()));
        end

        // Backpressure with id1/count7 pending
        req_valid = 4'b0010;
        req_data[1*W +: W] = 32'h01FF_0000;
        step();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("held id", 64'(rsp_id), 64'(1));
        check("held count", 64'(rsp_count), 64'(7));
        rsp_ready = 1'b1;
        step();
        check("no bubble id", 64'(rsp_id), 64'(2));

        // Asynchronous reset while a result is pending
        #2;
        rst = 1'b1;
        #1;
        check("async rsp_valid", 64'(rsp_valid), 64'(0));
        check("async req_ready", 64'(req_ready), 64'(0));
        do_reset();
        req_valid = 4'b1111;
        step();
        check("post-reset grant", 64'(last_grant), 64'(0));

        // Randomized traffic
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pdata[i] = $urandom >> $urandom_range(0, 32);
                end
                req_valid[i] = pend[i];
                req_data[i*W +: W] = pend[i] ? pdata[i] : $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            if (last_grant >= 0) pend[last_grant] = 1'b0;
        end

        // Three requesters, five-bit operands
        req_valid = '0;
        rsp_ready = 1'b1;
        do_reset();
        rv3 = 3'b111;
        rd3 = 15'($urandom);
        rdy3 = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i % 3));
        #1;
        check("n3 first ready", 64'(rr3), 64'(3'b001));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("n3 valid", 64'(vld3), 64'(1));
            check("n3 sequence", 64'(id3), 64'(exp_q.pop_front()));
        end
        rv3 = 3'b001;
        rd3 = '0;
        @(posedge clk);
        #1;
        check("n3 zero id", 64'(id3), 64'(0));
        check("n3 zero count", 64'(cnt3), 64'(5));
        check("n3 zero flag", 64'(zero3), 64'(1));
        rv3 = '0;
        @(posedge clk);
        #1;
        check("n3 drain", 64'(vld3), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
